// File: rtl/seven_seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: blank code,
// active-low hex glyph table ({g..a} order) and the digit-index width helper.
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational hex-to-segment decoder; output is active low, {g..a}.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/multi_seven_seg.sv
// Time-multiplexed common-anode driver with frame shadowing, blank/blink and
// PWM brightness. Define LEADING_ZERO_SUPPRESS_EN to blank leading zero digits.
module multi_seven_seg
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE_W = 11,
  parameter int BLINK_W    = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   val,
  input  logic [NUM_DIGITS-1:0]     dots,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic [NUM_DIGITS-1:0]     blink,
  input  logic [3:0]                brightness,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp
);

  localparam int               IDX_W    = idx_width(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [PRESCALE_W-1:0]   prescaler;
  logic [BLINK_W-1:0]      blink_cnt;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0]   sh_dots;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic [NUM_DIGITS-1:0]   sh_blink;

  logic                    tick;
  logic                    frame_end;
  logic [3:0]              duty;
  logic                    pwm_en;
  logic                    ghost;
  logic                    blink_dark;
  logic [3:0]              cur_hex;
  logic                    cur_dot;
  logic                    cur_supp;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   suppress;
  logic                    digit_on;
  logic                    anode_on;

  assign tick       = (prescaler == '1);
  assign frame_end  = tick && (idx == LAST_IDX);
  assign duty       = prescaler[PRESCALE_W-1 -: 4];
  assign pwm_en     = (brightness == 4'hF) || (duty < brightness);
  // Dead time at the start of every slot lets segments settle between digits.
  assign ghost      = (duty == 4'h0) && (brightness != 4'hF);
  assign blink_dark = blink_cnt[BLINK_W-1] && sh_blink[idx];
  assign cur_hex    = sh_val[{idx, 2'b00} +: 4];
  assign cur_dot    = sh_dots[idx];
  assign cur_supp   = suppress[idx];

`ifdef LEADING_ZERO_SUPPRESS_EN
  logic leading;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    leading  = 1'b1;
    suppress = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (sh_val[4*i +: 4] != 4'h0) leading = 1'b0;
      suppress[i] = leading;
    end
  end
`else
  assign suppress = '0;
`endif

  assign digit_on = pwm_en && !ghost && !sh_blank[idx] && !blink_dark;
  // A suppressed zero still drives its anode when only the decimal point is wanted.
  assign anode_on = digit_on && !(cur_supp && !cur_dot);

  seven_seg_decoder u_decoder (
    .hex (cur_hex),
    .seg (cur_seg)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler <= '0;
      blink_cnt <= '0;
      idx       <= '0;
      sh_val    <= '0;
      sh_dots   <= '0;
      sh_blank  <= '0;
      sh_blink  <= '0;
      an        <= '1;
      seg       <= SEG_BLANK;
      dp        <= 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
      blink_cnt <= blink_cnt + 1'b1;

      if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;

      if (frame_end) begin
        sh_val   <= val;
        sh_dots  <= dots;
        sh_blank <= blank;
        sh_blink <= blink;
      end

      if (anode_on) begin
        an  <= ~(NUM_DIGITS'(1) << idx);
        seg <= cur_supp ? SEG_BLANK : cur_seg;
        dp  <= ~cur_dot;
      end else begin
        an  <= '1;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multi_seven_seg.sv
// Scoreboard bench: stimulus pushes expected lit episodes (start cycle, an/seg/dp,
// length) per frame; monitors pop and compare whenever an anode lights.
module tb_multi_seven_seg;

  localparam int N_A = 4;
  localparam int N_B = 6;
  localparam int PW  = 5;
  localparam int BW  = 8;
`ifdef LEADING_ZERO_SUPPRESS_EN
  localparam bit LZS = 1'b1;
`else
  localparam bit LZS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [4*N_A-1:0] val_a;
  logic [N_A-1:0]   dots_a, blank_a, blink_a, an_a;
  logic [3:0]       bri_a;
  logic [6:0]       seg_a;
  logic             dp_a;

  logic [4*N_B-1:0] val_b;
  logic [N_B-1:0]   dots_b, blank_b, blink_b, an_b;
  logic [3:0]       bri_b;
  logic [6:0]       seg_b;
  logic             dp_b;

  always #5 clk = ~clk;

  multi_seven_seg #(.NUM_DIGITS(N_A), .PRESCALE_W(PW), .BLINK_W(BW)) dut_a (
    .clk(clk), .rst(rst), .val(val_a), .dots(dots_a), .blank(blank_a),
    .blink(blink_a), .brightness(bri_a), .an(an_a), .seg(seg_a), .dp(dp_a)
  );

  multi_seven_seg #(.NUM_DIGITS(N_B), .PRESCALE_W(PW), .BLINK_W(BW)) dut_b (
    .clk(clk), .rst(rst), .val(val_b), .dots(dots_b), .blank(blank_b),
    .blink(blink_b), .brightness(bri_b), .an(an_b), .seg(seg_b), .dp(dp_b)
  );

  typedef struct {
    int         t;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    int         len;
  } ep_t;

  ep_t q_a[$];
  ep_t q_b[$];
  int  tests = 0;
  int  fails = 0;
  int  tcyc  = 0;

  logic [6:0] glyph [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected episodes of frame f given the shadowed inputs for that frame.
  task automatic push_frame(input int which, input int n, input int f,
                            input logic [31:0] v, input logic [7:0] d, bl, bk,
                            input logic [3:0] bri, input logic ph);
    ep_t        e;
    logic [7:0] supp;
    logic       lead;
    int         len, off;
    supp = '0;
    lead = 1'b1;
    for (int i = n - 1; i > 0; i--) begin
      if (v[4*i +: 4] != 4'h0) lead = 1'b0;
      supp[i] = lead & LZS;
    end
    len = (bri == 4'hF) ? 32 : 2 * (int'(bri) - 1);
    off = (bri == 4'hF) ? 1 : 3;
    for (int i = 0; i < n; i++) begin
      if (len <= 0 || bl[i] || (ph && bk[i]) || (supp[i] && !d[i])) continue;
      e.t   = f * 32 * n + 32 * i + off;
      e.an  = ~(8'h01 << i);
      e.seg = supp[i] ? 7'h7F : glyph[v[4*i +: 4]];
      e.dp  = ~d[i];
      e.len = len;
      if (which == 0) q_a.push_back(e);
      else            q_b.push_back(e);
    end
  endtask

  task automatic goto(input int k);
    while (tcyc < k) begin
      @(negedge clk);
      tcyc++;
    end
    #1;
  endtask

  // Monitor for DUT A: every lit episode must be expected.
  int         cyc_a = 0, len_a = 0, illegal_a = 0;
  logic [3:0] cur_a = '1;
  bit         act_a = 1'b0;
  ep_t        e_a;

  always @(negedge clk) begin
    if (rst) begin
      cyc_a = 0;
      cur_a = '1;
      act_a = 1'b0;
    end else begin
      cyc_a++;
      if ($countones(~an_a) > 1) illegal_a++;
      if (an_a != cur_a) begin
        if (act_a) check("A episode length", 64'(len_a), 64'(e_a.len));
        act_a = 1'b0;
        if (an_a != '1) begin
          if (q_a.size() == 0) begin
            check("A unexpected lit an", 64'(an_a), 64'hF);
          end else begin
            e_a = q_a.pop_front();
            check("A episode start cycle", 64'(cyc_a), 64'(e_a.t));
            check("A an/seg/dp", {48'h0, 4'hF, an_a, seg_a, dp_a}, {48'h0, e_a.an, e_a.seg, e_a.dp});
            act_a = 1'b1;
            len_a = 1;
          end
        end
        cur_a = an_a;
      end else if (act_a) begin
        len_a++;
      end
    end
  end

  // Monitor for DUT B: checks the expected episodes, ignores later ones.
  int         cyc_b = 0, len_b = 0, illegal_b = 0;
  logic [5:0] cur_b = '1;
  bit         act_b = 1'b0;
  ep_t        e_b;

  always @(negedge clk) begin
    if (rst) begin
      cyc_b = 0;
      cur_b = '1;
      act_b = 1'b0;
    end else begin
      cyc_b++;
      if ($countones(~an_b) > 1) illegal_b++;
      if (an_b != cur_b) begin
        if (act_b) check("B episode length", 64'(len_b), 64'(e_b.len));
        act_b = 1'b0;
        if (an_b != '1 && q_b.size() != 0) begin
          e_b = q_b.pop_front();
          check("B episode start cycle", 64'(cyc_b), 64'(e_b.t));
          check("B an/seg/dp", {48'h0, 2'b11, an_b, seg_b, dp_b}, {48'h0, e_b.an, e_b.seg, e_b.dp});
          act_b = 1'b1;
          len_b = 1;
        end
        cur_b = an_b;
      end else if (act_b) begin
        len_b++;
      end
    end
  end

  initial begin
    val_a = 16'h1234; dots_a = 4'b0010; blank_a = '0; blink_a = '0; bri_a = 4'hF;
    val_b = 24'h654321; dots_b = 6'b100000; blank_b = '0; blink_b = '0; bri_b = 4'hF;

    repeat (3) @(negedge clk);
    check("reset an A", 64'(an_a), 64'hF);
    check("reset seg A", 64'(seg_a), 64'h7F);
    check("reset dp A", 64'(dp_a), 64'h1);
    check("reset an B", 64'(an_b), 64'h3F);

    push_frame(0, N_A, 0, 32'h0, 8'h0, 8'h0, 8'h0, 4'hF, 1'b0);
    push_frame(1, N_B, 0, 32'h0, 8'h0, 8'h0, 8'h0, 4'hF, 1'b0);
    push_frame(1, N_B, 1, 32'h654321, 8'h20, 8'h0, 8'h0, 4'hF, 1'b1);
    #1 rst = 1'b0;
    tcyc = 0;

    goto(128);
    push_frame(0, N_A, 1, 32'h1234, 8'h02, 8'h0, 8'h0, 4'hF, 1'b1);
    goto(256);
    push_frame(0, N_A, 2, 32'h1234, 8'h02, 8'h0, 8'h0, 4'hF, 1'b0);
    goto(256 + 40);
    val_a = 16'hABCD;
    goto(384);
    bri_a = 4'd4; blink_a = 4'b0001; blank_a = 4'b1000; dots_a = 4'b0000;
    push_frame(0, N_A, 3, 32'hABCD, 8'h02, 8'h0, 8'h0, 4'd4, 1'b1);
    goto(512);
    bri_a = 4'hF;
    push_frame(0, N_A, 4, 32'hABCD, 8'h00, 8'h08, 8'h01, 4'hF, 1'b0);
    goto(640);
    push_frame(0, N_A, 5, 32'hABCD, 8'h00, 8'h08, 8'h01, 4'hF, 1'b1);
    goto(768);
    bri_a = 4'h0; val_a = 16'h0050; dots_a = 4'b0100; blank_a = '0; blink_a = '0;
    goto(896);
    bri_a = 4'hF; val_a = 16'h0000; dots_a = 4'b0000;
    push_frame(0, N_A, 7, 32'h0050, 8'h04, 8'h0, 8'h0, 4'hF, 1'b1);
    goto(1024);
    val_a = 16'h1234;
    push_frame(0, N_A, 8, 32'h0, 8'h0, 8'h0, 8'h0, 4'hF, 1'b0);

    goto(1044);
    #1 rst = 1'b1;
    #1;
    check("async reset an A", 64'(an_a), 64'hF);
    check("async reset seg A", 64'(seg_a), 64'h7F);
    check("async reset dp A", 64'(dp_a), 64'h1);
    check("async reset an B", 64'(an_b), 64'h3F);
    q_a.delete();

    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    tcyc = 0;
    push_frame(0, N_A, 0, 32'h0, 8'h0, 8'h0, 8'h0, 4'hF, 1'b0);
    goto(128);
    bri_a = 4'h0;
    goto(140);

    check("A leftover episodes", 64'(q_a.size()), 64'h0);
    check("B leftover episodes", 64'(q_b.size()), 64'h0);
    check("A multi-hot an cycles", 64'(illegal_a), 64'h0);
    check("B multi-hot an cycles", 64'(illegal_b), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
